// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, mode constants and responder FSM encoding.
package spi_pkg;

  localparam int   SPI_WIDTH = 8;
  localparam logic SPI_CPOL  = 1'b0;
  localparam logic SPI_CPHA  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_port_if.sv
// Pin-side SPI signals plus the host-side word handshake of the SPI responder.
// Host handshake: tx_data is captured on a cycle where tx_load=1 and tx_ready=1; rx_data is valid in the rx_valid cycle.
interface spi_slave_port_if #(
  parameter int WIDTH = spi_pkg::SPI_WIDTH
);
  import spi_pkg::*;

  logic             sck;
  logic             ss_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic             busy;
  logic             frame_done;
  logic             frame_abort;
  logic             tx_underrun;
  spi_state_e       dbg_state;

  modport slave (
    input  sck, ss_n, mosi, tx_data, tx_load,
    output miso, miso_oe, rx_data, rx_valid, tx_ready, busy,
           frame_done, frame_abort, tx_underrun, dbg_state
  );

  modport master (
    output sck, ss_n, mosi, tx_data, tx_load,
    input  miso, miso_oe, rx_data, rx_valid, tx_ready, busy,
           frame_done, frame_abort, tx_underrun, dbg_state
  );

endinterface

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses
// derived from the previous vs. current synchronised sample.
module spi_input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
    prev_d  = chain_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign level = chain_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder: oversampled pins, MSB-first rx deserialiser and
// buffered tx serialiser, frames delimited by active-low SS.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DEFAULT_TX  = '0
) (
  input logic               clk,
  input logic               rst,
  spi_slave_port_if.slave   bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic       sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;
  logic [3:0] sync_unused;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d(bus.sck),
    .level(sync_unused[0]), .rise(sck_rise), .fall(sck_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .d(bus.ss_n),
    .level(sync_unused[1]), .rise(ss_rise), .fall(ss_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(bus.mosi),
    .level(mosi_s), .rise(sync_unused[2]), .fall(sync_unused[3])
  );

  spi_state_e       state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic             tx_full_q, tx_full_d;
  logic             miso_oe_q, miso_oe_d;
  logic             from_buf_q, from_buf_d;
  logic             commit_pend_q, commit_pend_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             under_q, under_d;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_shift_d    = tx_shift_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    miso_oe_d     = miso_oe_q;
    from_buf_d    = from_buf_q;
    commit_pend_d = commit_pend_q;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    under_d       = 1'b0;

    if (bus.tx_load && !tx_full_q) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        miso_oe_d = 1'b0;
        if (ss_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d       = ST_SHIFT;
        bit_cnt_d     = '0;
        miso_oe_d     = 1'b1;
        commit_pend_d = 1'b0;
        if (tx_full_q) begin
          tx_shift_d = tx_buf_q;
          tx_full_d  = 1'b0;
        end else begin
          tx_shift_d = DEFAULT_TX;
          under_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d       = ST_IDLE;
          miso_oe_d     = 1'b0;
          commit_pend_d = 1'b0;
          bit_cnt_d     = '0;
          if (bit_cnt_q == '0) done_d  = 1'b1;
          else                 abort_d = 1'b1;
        end else if (sck_rise) begin
          // A word-boundary reload only takes effect once its first bit is clocked,
          // so the trailing fall of a frame neither consumes the buffer nor flags underrun.
          if (commit_pend_q) begin
            commit_pend_d = 1'b0;
            if (from_buf_q) tx_full_d = 1'b0;
            else            under_d   = 1'b1;
          end
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = {rx_shift_q, mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            rx_shift_d = {rx_shift_q[WIDTH-3:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          end else begin
            commit_pend_d = 1'b1;
            from_buf_d    = tx_full_q;
            tx_shift_d    = tx_full_q ? tx_buf_q : DEFAULT_TX;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_shift_q    <= '0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      miso_oe_q     <= 1'b0;
      from_buf_q    <= 1'b0;
      commit_pend_q <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      under_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_shift_q    <= tx_shift_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      miso_oe_q     <= miso_oe_d;
      from_buf_q    <= from_buf_d;
      commit_pend_q <= commit_pend_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
      under_q       <= under_d;
    end
  end

  assign bus.miso        = miso_oe_q & tx_shift_q[WIDTH-1];
  assign bus.miso_oe     = miso_oe_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_ready    = ~tx_full_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;
  assign bus.tx_underrun = under_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: acts as a mode-0 SPI master at the
// minimum legal sck phase length and checks host-side results.
module tb_spi_slave_port;
  import spi_pkg::*;

  localparam int W     = 8;
  localparam int S     = 2;
  localparam int HALF  = S + 1;
  localparam int GUARD = S + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_port_if #(.WIDTH(W)) bus ();

  spi_slave_port #(.WIDTH(W), .SYNC_STAGES(S), .DEFAULT_TX(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Pulse monitor / scoreboard inputs
  int         n_rxv   = 0;
  int         n_done  = 0;
  int         n_abort = 0;
  int         n_under = 0;
  logic [W-1:0] rx_log [0:255];
  logic [W-1:0] exp_q [$];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[n_rxv[7:0]] <= bus.rx_data;
      n_rxv <= n_rxv + 1;
    end
    if (bus.frame_done)  n_done  <= n_done + 1;
    if (bus.frame_abort) n_abort <= n_abort + 1;
    if (bus.tx_underrun) n_under <= n_under + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [W-1:0] v);
    bus.tx_data = v;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  task automatic ss_low();
    bus.ss_n = 1'b0;
    idle(GUARD);
  endtask

  task automatic ss_high();
    idle(GUARD);
    bus.ss_n = 1'b1;
    idle(GUARD + 3);
  endtask

  // Shifts nbits of mo; optionally loads ldv into the tx buffer mid-word.
  task automatic xfer(input logic [W-1:0] mo, input int nbits, input logic ld,
                      input logic [W-1:0] ldv, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[W-1-i];
      idle(HALF);
      mi = {mi[W-2:0], bus.miso};
      bus.sck = 1'b1;
      if (ld && i == 3) begin
        check("tx_ready_before_load", bus.tx_ready, 1'b1);
        load_tx(ldv);
        idle(HALF - 1);
      end else begin
        idle(HALF);
      end
      bus.sck = 1'b0;
    end
  endtask

  logic [W-1:0] mi, mi0, mi1, mi2;
  int b_rxv, b_done, b_abort, b_under;
  logic [W-1:0] mo_v [32];
  logic [W-1:0] tx_v [32];

  task automatic snap();
    b_rxv   = n_rxv;
    b_done  = n_done;
    b_abort = n_abort;
    b_under = n_under;
  endtask

  initial begin
    bus.sck     = 1'b0;
    bus.ss_n    = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    rst         = 1'b0;
    idle(3);

    // Reset values
    check("rst_miso", bus.miso, 1'b0);
    check("rst_miso_oe", bus.miso_oe, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_tx_ready", bus.tx_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    idle(3);

    // Single byte frame
    snap();
    load_tx(8'hA5);
    check("t1_tx_ready_full", bus.tx_ready, 1'b0);
    ss_low();
    check("t1_busy", bus.busy, 1'b1);
    check("t1_miso_oe", bus.miso_oe, 1'b1);
    check("t1_tx_ready_after_load", bus.tx_ready, 1'b1);
    xfer(8'h3C, 8, 1'b0, 8'h00, mi);
    ss_high();
    check("t1_miso_word", mi, 8'hA5);
    check("t1_rx_count", n_rxv - b_rxv, 1);
    check("t1_rx_word", rx_log[b_rxv[7:0]], 8'h3C);
    check("t1_rx_data", bus.rx_data, 8'h3C);
    check("t1_done", n_done - b_done, 1);
    check("t1_abort", n_abort - b_abort, 0);
    check("t1_under", n_under - b_under, 0);
    check("t1_busy_end", bus.busy, 1'b0);
    check("t1_oe_end", bus.miso_oe, 1'b0);

    // Three byte frame, second tx word supplied mid-word, third underruns
    snap();
    load_tx(8'h11);
    ss_low();
    xfer(8'h01, 8, 1'b1, 8'h22, mi0);
    xfer(8'h80, 8, 1'b0, 8'h00, mi1);
    xfer(8'hFF, 8, 1'b0, 8'h00, mi2);
    ss_high();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hFF);
    check("t2_rx_count", n_rxv - b_rxv, 3);
    for (int k = 0; k < 3; k++) check("t2_rx_word", rx_log[8'(b_rxv + k)], exp_q.pop_front());
    check("t2_miso0", mi0, 8'h11);
    check("t2_miso1", mi1, 8'h22);
    check("t2_miso2", mi2, 8'h00);
    check("t2_under", n_under - b_under, 1);
    check("t2_done", n_done - b_done, 1);
    check("t2_tx_ready", bus.tx_ready, 1'b1);

    // Abort after 5 bits, then a clean frame
    snap();
    ss_low();
    xfer(8'hB7, 5, 1'b0, 8'h00, mi);
    ss_high();
    check("t3_rx_count", n_rxv - b_rxv, 0);
    check("t3_abort", n_abort - b_abort, 1);
    check("t3_done", n_done - b_done, 0);
    check("t3_oe", bus.miso_oe, 1'b0);
    check("t3_under", n_under - b_under, 1);
    snap();
    load_tx(8'h96);
    ss_low();
    xfer(8'h5A, 8, 1'b0, 8'h00, mi);
    ss_high();
    check("t3b_rx_count", n_rxv - b_rxv, 1);
    check("t3b_rx_word", rx_log[b_rxv[7:0]], 8'h5A);
    check("t3b_miso", mi, 8'h96);
    check("t3b_done", n_done - b_done, 1);
    check("t3b_abort", n_abort - b_abort, 0);

    // Reset in the middle of a frame
    load_tx(8'h77);
    ss_low();
    xfer(8'hE0, 3, 1'b0, 8'h00, mi);
    load_tx(8'h88);
    check("t4_tx_ready_pre", bus.tx_ready, 1'b0);
    check("t4_busy_pre", bus.busy, 1'b1);
    rst      = 1'b0;
    bus.ss_n = 1'b1;
    bus.sck  = 1'b0;
    idle(2);
    snap();
    check("t4_rst_miso", bus.miso, 1'b0);
    check("t4_rst_oe", bus.miso_oe, 1'b0);
    check("t4_rst_rx_data", bus.rx_data, 8'h00);
    check("t4_rst_rx_valid", bus.rx_valid, 1'b0);
    check("t4_rst_tx_ready", bus.tx_ready, 1'b1);
    check("t4_rst_busy", bus.busy, 1'b0);
    check("t4_rst_pulses", {bus.frame_done, bus.frame_abort, bus.tx_underrun}, 3'b000);
    rst = 1'b1;
    idle(8);
    check("t4_no_stale_abort", n_abort - b_abort, 0);
    check("t4_no_stale_done", n_done - b_done, 0);
    check("t4_no_stale_rx", n_rxv - b_rxv, 0);
    check("t4_state_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
    load_tx(8'h3C);
    ss_low();
    xfer(8'hC3, 8, 1'b0, 8'h00, mi);
    ss_high();
    check("t4_rx_count", n_rxv - b_rxv, 1);
    check("t4_rx_data", bus.rx_data, 8'hC3);
    check("t4_miso", mi, 8'h3C);
    check("t4_done", n_done - b_done, 1);
    check("t4_abort", n_abort - b_abort, 0);
    check("t4_under", n_under - b_under, 0);

    // 32 random bytes both directions at the minimum sck phase length
    for (int k = 0; k < 32; k++) begin
      mo_v[k] = 8'($urandom_range(0, 255));
      tx_v[k] = 8'($urandom_range(0, 255));
    end
    snap();
    load_tx(tx_v[0]);
    ss_low();
    for (int k = 0; k < 32; k++) begin
      xfer(mo_v[k], 8, (k < 31), (k < 31) ? tx_v[(k + 1) % 32] : 8'h00, mi);
      check("t5_miso_word", mi, tx_v[k]);
      exp_q.push_back(mo_v[k]);
    end
    ss_high();
    check("t5_rx_count", n_rxv - b_rxv, 32);
    for (int k = 0; k < 32; k++) check("t5_rx_word", rx_log[8'(b_rxv + k)], exp_q.pop_front());
    check("t5_done", n_done - b_done, 1);
    check("t5_under", n_under - b_under, 0);

    // sck activity with SS high must be ignored
    snap();
    for (int k = 0; k < 8; k++) begin
      bus.mosi = 1'($urandom_range(0, 1));
      bus.sck  = 1'b1;
      idle(HALF);
      bus.sck  = 1'b0;
      idle(HALF);
    end
    idle(GUARD);
    check("t5_idle_rx", n_rxv - b_rxv, 0);
    check("t5_idle_pulses", (n_done - b_done) + (n_abort - b_abort) + (n_under - b_under), 0);
    check("t5_idle_busy", bus.busy, 1'b0);
    check("t5_idle_oe", bus.miso_oe, 1'b0);
    check("t5_idle_miso", bus.miso, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
